pio_led_out: RTL
================

# pio_led_out

Avalon-MM slave output PIO driving the board LEDs from the NIOS II: the CPU writes a data register whose bits appear on `out_port`. Bits can be set or cleared atomically without read-modify-write. An optional per-bit hardware blink engine is also provided. It is the write-side companion of the switch input PIO and sits on the same system interconnect.

## Interface
- `WIDTH`, 18: number of output bits; 1..32.
- `RESET_VALUE`, 0: value of the data register after reset; `WIDTH` bits.
- `DIV_W`, 24: width of the blink divider; 1..32.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  register word address.
- `chipselect`  in  1  slave selected.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  in  32  write data; bits above the register width are ignored.
- `readdata`  out  32  registered read data; zero-extended.
- `out_port`  out  `WIDTH`  LED drive.

## Operation
- Register map:
  - 0 DATA (R/W): a write replaces the data register.
  - 1 BLINK_MASK (R/W, `WIDTH` bits).
  - 2 BLINK_DIV (R/W, `DIV_W` bits).
  - 3 STATUS (R): bit0 = phase, bit1 = blink active (BLINK_DIV != 0); other bits 0.
  - 4 OUTSET (W): data |= writedata.
  - 5 OUTCLEAR (W): data &= ~writedata.
  - Addresses 4–7 read 0. Writes to 3, 6 and 7 are ignored.
- Output: `out_port = data ^ (BLINK_MASK & {WIDTH{phase}})`. `out_port` is a register.
- Blink engine:
  - Down-counter `cnt` (`DIV_W` bits).
  - When BLINK_DIV == 0: `cnt` is held at 0 and phase is forced to 0.
  - Otherwise, when `cnt == 0`, load `cnt = BLINK_DIV - 1` and toggle phase; else `cnt` decrements.
  - The phase half-period is therefore BLINK_DIV cycles.
- A write to BLINK_DIV loads `cnt = newvalue - 1`, or 0 if the new value is 0. Phase is unchanged, except that it is forced to 0 when the new value is 0.
- The read mux is evaluated every cycle regardless of chipselect, as in the input PIO. `readdata` holds the selected register value.

## Timing
- Reset values:
  - data = `RESET_VALUE`; BLINK_MASK = 0; BLINK_DIV = 0; `cnt` = 0; phase = 0.
  - `readdata` = 0.
  - `out_port` = `RESET_VALUE`.
- Write latency: a write accepted at clock edge N is visible on `out_port` and in the register after edge N+1, i.e. one registered stage. No wait states.
- Read latency: `readdata` updates at the edge after `address` is presented (latency 1). A read in the cycle after a write returns the new value.
- Phase toggle at edge N is visible on `out_port` after edge N+1.
- Simultaneous events:
  - A DATA/OUTSET/OUTCLEAR write coinciding with a phase toggle: both apply in the same edge, and the output reflects the new data XOR the new phase.
  - A BLINK_DIV write coinciding with `cnt == 0`: the write wins, the reload uses the new value, and phase does not toggle.
- Clearing a BLINK_MASK bit returns that output to its data bit on the next update, whatever the phase.
- Reset asserted mid-blink: all state returns to reset values asynchronously, and `out_port` = `RESET_VALUE` immediately.

## Configuration
- `PIO_LED_BLINK_EN`:
  - Defined: blink engine, BLINK_MASK, BLINK_DIV and STATUS are present.
  - Undefined: no counter or phase logic. Addresses 1–3 read 0 and writes to them are ignored. `out_port = data`. DATA/OUTSET/OUTCLEAR timing is identical in both builds.

## Structure
- Package `pio_led_pkg`: the address constants `PIO_ADDR_DATA`, `PIO_ADDR_MASK`, `PIO_ADDR_DIV`, `PIO_ADDR_STATUS`, `PIO_ADDR_OUTSET`, `PIO_ADDR_OUTCLR`.
- Sub-module `pio_blink_timer`:
  - Holds `cnt` and phase.
  - Inputs: `div`, `load`, `load_val`.
  - Output: `phase`.
  - Instantiated only under `PIO_LED_BLINK_EN`.

## Test plan
- Reset with `RESET_VALUE = 18'h00F0` -> `out_port` = 00F0 and `readdata` = 0 during reset; a DATA read after reset returns 0x00F0.
- Write DATA = 0x3FFFF, then OUTCLEAR 0x00005, then OUTSET 0x40000 -> `out_port` = 3FFFF, then 3FFFA; the bit-18 write is ignored, so the value stays 3FFFA. The final DATA read returns 0x3FFFA.
- Blink: DATA = 0, MASK = 0x3, DIV = 4 -> `out_port` alternates 0 and 3 every 4 cycles; STATUS bit1 = 1.
- Write DIV = 4 in the same cycle that `cnt` reaches 0 -> no toggle that cycle; the next toggle occurs 4 cycles later.
- Mid-blink with phase = 1, write MASK = 0 -> `out_port` = DATA on the next update; DIV = 0 -> STATUS = 0.
- Build without the macro: write MASK = 0x3 and DIV = 2 -> `out_port` never toggles; address 1 reads 0.

Source files
------------

// File: rtl/pio_led_pkg.sv
// Shared constants for the LED output PIO: register word addresses.
package pio_led_pkg;

    localparam int unsigned PIO_ADDR_W = 3;

    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA   = 3'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_MASK   = 3'd1;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DIV    = 3'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_STATUS = 3'd3;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_OUTSET = 3'd4;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_OUTCLR = 3'd5;

endpackage

// File: rtl/pio_blink_timer.sv
// Blink phase generator: DIV_W-bit down-counter plus a phase bit that
// toggles every `div` cycles.
//   clk, reset_n : clock, async active-low reset
//   div          : current half-period in cycles (0 = blink off, phase held 0)
//   load         : BLINK_DIV write this cycle; takes priority over counting
//   load_val     : value being written to BLINK_DIV
//   phase        : registered blink phase
module pio_blink_timer #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             phase
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // A divider write restarts the count and suppresses any coincident toggle.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            if (load_val == '0) begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end else begin
                cnt_d = load_val - DIV_W'(1);
            end
        end else if (div == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = div - DIV_W'(1);
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/pio_led_out.sv
// Avalon-MM output PIO for the board LEDs, with atomic set/clear and an
// optional per-bit hardware blink engine (enabled by macro PIO_LED_BLINK_EN).
//   clk, reset_n : clock, async active-low reset
//   address      : register word address
//   chipselect   : slave select; write when chipselect && !write_n
//   write_n      : active-low write strobe
//   writedata    : write data, bits above register width ignored
//   readdata     : registered, zero-extended read data (latency 1)
//   out_port     : registered LED drive
module pio_led_out
    import pio_led_pkg::*;
#(
    parameter int unsigned      WIDTH       = 18,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      DIV_W       = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PIO_ADDR_W-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [WIDTH-1:0]      out_port
);

    logic             wr_c;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             unused_wdata;

    assign wr_c         = chipselect && !write_n;
    assign wdata_c      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Data register: full replace, atomic set, atomic clear.
    always_comb begin
        data_d = data_q;
        if (wr_c) begin
            case (address)
                PIO_ADDR_DATA:   data_d = wdata_c;
                PIO_ADDR_OUTSET: data_d = data_q | wdata_c;
                PIO_ADDR_OUTCLR: data_d = data_q & ~wdata_c;
                default:         data_d = data_q;
            endcase
        end
    end

`ifdef PIO_LED_BLINK_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             div_load_c;
    logic             phase;

    // Blink configuration registers.
    always_comb begin
        mask_d     = mask_q;
        div_d      = div_q;
        div_load_c = 1'b0;
        if (wr_c) begin
            case (address)
                PIO_ADDR_MASK: mask_d = wdata_c;
                PIO_ADDR_DIV: begin
                    div_d      = writedata[DIV_W-1:0];
                    div_load_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            div_q  <= '0;
        end else begin
            mask_q <= mask_d;
            div_q  <= div_d;
        end
    end

    pio_blink_timer #(
        .DIV_W (DIV_W)
    ) u_blink_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .div      (div_q),
        .load     (div_load_c),
        .load_val (div_d),
        .phase    (phase)
    );

    assign out_d = data_q ^ (mask_q & {WIDTH{phase}});
`else
    assign out_d = data_q;
`endif

    // Read mux runs every cycle, independent of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            PIO_ADDR_DATA:   readdata_d = 32'(data_q);
`ifdef PIO_LED_BLINK_EN
            PIO_ADDR_MASK:   readdata_d = 32'(mask_q);
            PIO_ADDR_DIV:    readdata_d = 32'(div_q);
            PIO_ADDR_STATUS: readdata_d = {30'd0, (div_q != '0), phase};
`endif
            default:         readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            out_q      <= RESET_VALUE;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            out_q      <= out_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port = out_q;
    assign readdata = readdata_q;

endmodule
